// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// encodings, the shadow-scoreboard slot layout and the slot match helper.
package hazard_ctrl_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_CNT_W      = 16;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_EX      = 2'd1;
   localparam logic [1:0] FWD_MEM     = 2'd2;
   localparam logic [1:0] FWD_WB      = 2'd3;

   localparam int SLOT_VALID_W = 1;
   localparam int SLOT_WR_W    = 1;
   localparam int SLOT_DST_W   = DEF_REG_ADDR_W;
   localparam int SLOT_LOAD_W  = 1;

   typedef struct packed {
      logic [SLOT_VALID_W-1:0] valid;
      logic [SLOT_WR_W-1:0]    wr;
      logic [SLOT_DST_W-1:0]   dst;
      logic [SLOT_LOAD_W-1:0]  is_load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wr: 1'b0, dst: {SLOT_DST_W{1'b0}}, is_load: 1'b0};

   // r0 is hard-wired zero, so a write to it never creates a dependency
   function automatic logic slot_match(input slot_t s, input logic [SLOT_DST_W-1:0] src,
                                       input logic rd_en);
      return s.valid[0] && s.wr[0] && (s.dst == src) && (src != {SLOT_DST_W{1'b0}}) && rd_en;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage side bundle of the hazard controller: decoded fields and flags in,
// stall/flush/forwarding controls and performance counters out.
interface hazard_ctrl_if
#(
   parameter int REG_ADDR_W = hazard_ctrl_pkg::DEF_REG_ADDR_W,
   parameter int CNT_W      = hazard_ctrl_pkg::DEF_CNT_W
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_rs_read_en;
   logic                  id_rt_read_en;
   logic                  id_reg_write;
   logic [REG_ADDR_W-1:0] id_wr_dst;
   logic                  id_mem_read_en;
   logic                  ex_branch_taken;
   logic                  mem_busy;
   logic                  stall_if;
   logic                  stall_id;
   logic                  bubble_ex;
   logic                  flush_if_id;
   logic [1:0]            fwd_rs_sel;
   logic [1:0]            fwd_rt_sel;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_read_en, id_rt_read_en, id_reg_write,
             id_wr_dst, id_mem_read_en, ex_branch_taken, mem_busy,
      input  stall_if, stall_id, bubble_ex, flush_if_id, fwd_rs_sel, fwd_rt_sel,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_read_en, id_rt_read_en, id_reg_write,
             id_wr_dst, id_mem_read_en, ex_branch_taken, mem_busy,
      output stall_if, stall_id, bubble_ex, flush_if_id, fwd_rs_sel, fwd_rt_sel,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and forwarding scheduler beside ID: tracks EX/MEM/WB writers in a
// shadow scoreboard and drives stall, bubble, flush and bypass selects.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
)
(
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);
   slot_t ex_q, mem_q, wb_q;
   slot_t ex_d, mem_d, wb_d;

   logic ex_rs_hit_s, ex_rt_hit_s, load_use_s, issue_s;
   logic stall_if_s, stall_id_s, bubble_ex_s, flush_s;
   logic stall_inc_s, flush_inc_s;

   // A load still in EX cannot be bypassed; the stall covers it, so it selects the regfile
   function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src, input logic rd_en,
                                             input slot_t ex, input slot_t mem, input slot_t wb);
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if (slot_match(ex, src, rd_en)) begin
         sel = ex.is_load[0] ? FWD_REGFILE : FWD_EX;
      end else if (slot_match(mem, src, rd_en)) begin
         sel = FWD_MEM;
      end else if (slot_match(wb, src, rd_en)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_REGFILE;
      end
      return sel;
   endfunction

   assign ex_rs_hit_s = slot_match(ex_q, bus.id_rs, bus.id_rs_read_en);
   assign ex_rt_hit_s = slot_match(ex_q, bus.id_rt, bus.id_rt_read_en);
   assign load_use_s  = bus.id_valid && ex_q.is_load[0] && (ex_rs_hit_s || ex_rt_hit_s);
   assign issue_s     = rst && bus.id_valid && !load_use_s && !bus.ex_branch_taken && !bus.mem_busy;

   always_comb begin
      stall_if_s  = 1'b0;
      stall_id_s  = 1'b0;
      bubble_ex_s = 1'b0;
      flush_s     = 1'b0;
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
      if (!rst) begin
         stall_if_s = 1'b0;
      end else if (bus.mem_busy) begin
         stall_if_s = 1'b1;
         stall_id_s = 1'b1;
      end else if (bus.ex_branch_taken) begin
         flush_s     = 1'b1;
         bubble_ex_s = 1'b1;
         flush_inc_s = 1'b1;
      end else if (load_use_s) begin
         stall_if_s  = 1'b1;
         stall_id_s  = 1'b1;
         bubble_ex_s = 1'b1;
         stall_inc_s = 1'b1;
      end else begin
         stall_if_s = 1'b0;
      end
   end

   // Scoreboard shifts only while memory is ready; anything not issued enters EX as a bubble
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!bus.mem_busy) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (issue_s) begin
            ex_d = '{valid: 1'b1, wr: bus.id_reg_write, dst: bus.id_wr_dst,
                     is_load: bus.id_mem_read_en};
         end else begin
            ex_d = SLOT_EMPTY;
         end
      end else begin
         ex_d = ex_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q  <= SLOT_EMPTY;
         mem_q <= SLOT_EMPTY;
         wb_q  <= SLOT_EMPTY;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign bus.stall_if    = stall_if_s;
   assign bus.stall_id    = stall_id_s;
   assign bus.bubble_ex   = bubble_ex_s;
   assign bus.flush_if_id = flush_s;
   assign bus.fwd_rs_sel  = fwd_select(bus.id_rs, bus.id_rs_read_en, ex_q, mem_q, wb_q);
   assign bus.fwd_rt_sel  = fwd_select(bus.id_rt, bus.id_rt_read_en, ex_q, mem_q, wb_q);

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stall_inc_s),
      .count_o (bus.stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (flush_inc_s),
      .count_o (bus.flush_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expected controls are queued with
// the stimulus and compared on the falling edge. Counters are 8 bits wide here.
module tb_hazard_ctrl;
   localparam int AW = 5;
   localparam int CW = 8;
   localparam logic [3:0] C_NONE   = 4'b0000;
   localparam logic [3:0] C_STALL  = 4'b1110;
   localparam logic [3:0] C_FLUSH  = 4'b0011;
   localparam logic [3:0] C_FREEZE = 4'b1100;

   typedef struct packed {
      logic [3:0]    ctl;
      logic [1:0]    frs;
      logic [1:0]    frt;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } obs_t;

   typedef struct {
      logic rst_n; logic v;
      logic [AW-1:0] rs; logic rse; logic [AW-1:0] rt; logic rte;
      logic wr; logic [AW-1:0] dst; logic ld; logic br; logic busy;
      logic [3:0] ctl; logic [1:0] frs; logic [1:0] frt;
   } stim_t;

   logic clk;
   logic rst;
   stim_t tbl[$];
   obs_t  exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic [CW-1:0] exp_sc = 8'd0;
   logic [CW-1:0] exp_fc = 8'd0;

   hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();
   hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic v, input logic [AW-1:0] rs, input logic rse,
                      input logic [AW-1:0] rt, input logic rte, input logic wr,
                      input logic [AW-1:0] dst, input logic ld, input logic br, input logic busy,
                      input logic [3:0] ctl, input logic [1:0] frs, input logic [1:0] frt);
      stim_t s;
      s.rst_n = 1'b1; s.v = v; s.rs = rs; s.rse = rse; s.rt = rt; s.rte = rte;
      s.wr = wr; s.dst = dst; s.ld = ld; s.br = br; s.busy = busy;
      s.ctl = ctl; s.frs = frs; s.frt = frt;
      tbl.push_back(s);
   endtask

   task automatic apply(input stim_t s);
      rst                 = s.rst_n;
      bus.id_valid        = s.v;
      bus.id_rs           = s.rs;
      bus.id_rs_read_en   = s.rse;
      bus.id_rt           = s.rt;
      bus.id_rt_read_en   = s.rte;
      bus.id_reg_write    = s.wr;
      bus.id_wr_dst       = s.dst;
      bus.id_mem_read_en  = s.ld;
      bus.ex_branch_taken = s.br;
      bus.mem_busy        = s.busy;
   endtask

   function automatic obs_t mk(input stim_t s);
      if (!s.rst_n) return '0;
      return obs_t'({s.ctl, s.frs, s.frt, exp_sc, exp_fc});
   endfunction

   task automatic upd(input stim_t s);
      if (!s.rst_n) begin
         exp_sc = 8'd0;
         exp_fc = 8'd0;
      end else begin
         if (s.ctl == C_STALL && exp_sc != 8'hFF) exp_sc = exp_sc + 8'd1;
         if (s.ctl[0] && exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
      end
   endtask

   function automatic obs_t sample();
      return obs_t'({bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_if_id,
                     bus.fwd_rs_sel, bus.fwd_rt_sel, bus.stall_cnt, bus.flush_cnt});
   endfunction

   task automatic drain();
      bus.id_valid = 1'b0; bus.id_rs_read_en = 1'b0; bus.id_rt_read_en = 1'b0;
      bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0; bus.id_reg_write = 1'b0;
      bus.id_mem_read_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t s; obs_t e, got; int k = 0;
      add(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, C_NONE, 2'd0, 2'd0);
      tbl[tbl.size()-1].rst_n = 1'b0;
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL reset step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 2'd0);
      add(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 2'd2);
      add(1'b1, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd2);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL back_to_back step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_distance();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd2, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL distance step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd3, 2'd2);
      add(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_NONE, 2'd2, 2'd0);
      add(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 2'd0);
      add(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd2, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL distance step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      add(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 2'd0);
      add(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_NONE,  2'd0, 2'd2);
      add(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      add(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 2'd0);
      add(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE,  2'd2, 2'd0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      add(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL load_use step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_r0();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      add(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL r0 step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_vs_stall();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
      add(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, C_FLUSH, 2'd0, 2'd0);
      add(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, C_FLUSH, 2'd0, 2'd0);
      add(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE,  2'd0, 2'd3);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL branch_vs_stall step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_freeze();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NONE,   2'd0, 2'd0);
      add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE,   2'd0, 2'd0);
      add(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, C_FREEZE, 2'd2, 2'd0);
      add(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, C_FREEZE, 2'd2, 2'd0);
      add(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, C_FREEZE, 2'd2, 2'd0);
      add(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_STALL,  2'd2, 2'd0);
      add(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_NONE,   2'd3, 2'd2);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL freeze step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_freeze();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      add(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, C_NONE,   2'd0, 2'd0);
      add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE,   2'd0, 2'd0);
      add(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, C_FREEZE, 2'd2, 2'd0);
      add(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, C_NONE,   2'd0, 2'd0);
      tbl[tbl.size()-1].rst_n = 1'b0;
      add(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_NONE,   2'd0, 2'd0);
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL reset_mid_freeze step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation();
      stim_t s; obs_t e, got; int k = 0;
      drain();
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         add(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE,  2'd0, 2'd0);
         add(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_STALL, 2'd0, 2'd0);
      end
      while (tbl.size() != 0) begin
         s = tbl.pop_front(); apply(s); exp_q.push_back(mk(s)); k++;
         @(negedge clk);
         e = exp_q.pop_front(); got = sample(); n_cmp++;
         if (got !== e) begin n_bad++; $display("FAIL saturation step %0d: got %h required %h", k, got, e); end
         upd(s); @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.stall_cnt !== 8'hFF) begin
         n_bad++;
         $display("FAIL stall_cnt_saturated: got %h required ff", bus.stall_cnt);
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      bus.id_rs_read_en = 1'b0; bus.id_rt_read_en = 1'b0; bus.id_reg_write = 1'b0;
      bus.id_wr_dst = 5'd0; bus.id_mem_read_en = 1'b0;
      bus.ex_branch_taken = 1'b0; bus.mem_busy = 1'b0;
      #2;
      test_reset();
      test_back_to_back();
      test_distance();
      test_load_use();
      test_r0();
      test_branch_vs_stall();
      test_freeze();
      test_reset_mid_freeze();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
